// File: rtl/rom_dl_sequencer.sv
// rom_dl_sequencer: routes the HPS ROM download stream to SDRAM ports
// and the on-chip gfx loader, and generates the stretched core reset.
module rom_dl_sequencer #(
  parameter logic [24:0] SP_BASE  = 25'h12000,
  parameter logic [24:0] GFX_BASE = 25'h32000,
  parameter logic [15:0] RST_CNT  = 16'hFFFF
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        user_reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [18:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        dl_wr,
  output logic [24:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic [7:0]  game_mod,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic        dl_overrun
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        need_p1;
  logic        need_p2;
  logic        dl_seen;
  logic [15:0] cnt;
  logic        accept;
  logic        sel_wr;
  logic        in_g;
  logic        in_s;
  logic        p1_ok;
  logic        p2_ok;
  logic        rst_src;
  logic [24:0] offs;
  logic        unused_bits;

  assign accept  = ioctl_wr && ioctl_download
                 && (ioctl_index == 8'd0) && (state == IDLE);
  assign sel_wr  = ioctl_wr && ioctl_download
                 && (ioctl_index == 8'd1) && (state == IDLE);
  assign in_g    = (ioctl_addr >= GFX_BASE);
  assign in_s    = !in_g && (ioctl_addr >= SP_BASE);
  assign offs    = ioctl_addr - SP_BASE;
  assign p1_ok   = !need_p1 || (port1_ack == port1_req);
  assign p2_ok   = !need_p2 || (port2_ack == port2_req);
  assign rst_src = RESET | user_reset | ~rom_loaded | ioctl_download;
  assign ioctl_wait = (state != IDLE);
  assign unused_bits = ^{offs[24:19], ioctl_addr[24]};

  // state register
  always_ff @(posedge clk_sys) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state: gfx bytes skip the ack wait
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (accept) state_nx = ISSUE;
      ISSUE:    state_nx = (need_p1 || need_p2) ? WAIT_ACK : IDLE;
      WAIT_ACK: if (p1_ok && p2_ok) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // byte capture, request toggles and status flags
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      need_p1    <= 1'b0;
      need_p2    <= 1'b0;
      port1_req  <= 1'b0;
      port1_a    <= '0;
      port1_ds   <= '0;
      port1_d    <= '0;
      port2_req  <= 1'b0;
      port2_a    <= '0;
      port2_ds   <= '0;
      port2_d    <= '0;
      dl_wr      <= 1'b0;
      dl_addr    <= '0;
      dl_data    <= '0;
      game_mod   <= '0;
      rom_loaded <= 1'b0;
      dl_overrun <= 1'b0;
      dl_seen    <= 1'b0;
    end else begin
      dl_wr <= 1'b0;
      if (accept) begin
        need_p1 <= !in_g;
        need_p2 <= in_s;
        if (in_g) begin
          dl_wr   <= 1'b1;
          dl_addr <= ioctl_addr - GFX_BASE;
          dl_data <= ioctl_dout;
        end else begin
          port1_a  <= ioctl_addr[23:1];
          port1_ds <= {ioctl_addr[0], ~ioctl_addr[0]};
          port1_d  <= {ioctl_dout, ioctl_dout};
          if (in_s) begin
            port2_a  <= {1'b0, offs[18:17], offs[14:0], offs[16]};
            port2_ds <= {offs[15], ~offs[15]};
            port2_d  <= {ioctl_dout, ioctl_dout};
          end
        end
      end
      if (state == ISSUE) begin
        if (need_p1) port1_req <= ~port1_req;
        if (need_p2) port2_req <= ~port2_req;
      end
      if (sel_wr) game_mod <= ioctl_dout;
      if (ioctl_wr && (state != IDLE)) dl_overrun <= 1'b1;
      if (ioctl_download && (ioctl_index == 8'd0)) dl_seen <= 1'b1;
      if ((state == IDLE) && dl_seen && !ioctl_download)
        rom_loaded <= 1'b1;
    end
  end

  // reset stretch: second pulse when the counter reaches 1
  always_ff @(posedge clk_sys) begin
    if (rst_src)          cnt <= RST_CNT;
    else if (cnt != '0)   cnt <= cnt - 16'd1;
    core_reset <= rst_src | (cnt == 16'd1);
  end

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// tb_rom_dl_sequencer: directed checks of routing, handshakes,
// overrun, game select, load flag and reset stretch.
module tb_rom_dl_sequencer;

  logic        clk_sys = 1'b0;
  logic        RESET;
  logic        user_reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        port1_req;
  logic        port1_ack;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;
  logic        port2_req;
  logic        port2_ack;
  logic [18:0] port2_a;
  logic [1:0]  port2_ds;
  logic [15:0] port2_d;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic [7:0]  game_mod;
  logic        rom_loaded;
  logic        core_reset;
  logic        dl_overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  rom_dl_sequencer #(
    .SP_BASE(25'h12000),
    .GFX_BASE(25'h32000),
    .RST_CNT(16'd16)
  ) dut (
    .clk_sys(clk_sys),
    .RESET(RESET),
    .user_reset(user_reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr),
    .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .port1_req(port1_req),
    .port1_ack(port1_ack),
    .port1_a(port1_a),
    .port1_ds(port1_ds),
    .port1_d(port1_d),
    .port2_req(port2_req),
    .port2_ack(port2_ack),
    .port2_a(port2_a),
    .port2_ds(port2_ds),
    .port2_d(port2_d),
    .dl_wr(dl_wr),
    .dl_addr(dl_addr),
    .dl_data(dl_data),
    .game_mod(game_mod),
    .rom_loaded(rom_loaded),
    .core_reset(core_reset),
    .dl_overrun(dl_overrun)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    RESET = 1'b1;
    user_reset = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_index = 8'd0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    port1_ack = 1'b0;
    port2_ack = 1'b0;
    tick(2);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_wait", 32'(ioctl_wait), 32'd0);
    chk("rst_p1req", 32'(port1_req), 32'd0);
    chk("rst_p2req", 32'(port2_req), 32'd0);
    chk("rst_loaded", 32'(rom_loaded), 32'd0);
    chk("rst_overrun", 32'(dl_overrun), 32'd0);
    chk("rst_game_mod", 32'(game_mod), 32'd0);
    RESET = 1'b0;
    tick(1);

    // game-select byte
    ioctl_download = 1'b1;
    ioctl_index = 8'd1;
    ioctl_dout = 8'h03;
    ioctl_wr = 1'b1;
    tick(1);
    ioctl_wr = 1'b0;
    chk("gsel_game_mod", 32'(game_mod), 32'h03);
    chk("gsel_wait", 32'(ioctl_wait), 32'd0);
    ioctl_download = 1'b0;
    tick(2);
    chk("gsel_not_loaded", 32'(rom_loaded), 32'd0);

    // region A, with a dropped byte mid-handshake
    ioctl_download = 1'b1;
    ioctl_index = 8'd0;
    ioctl_addr = 25'h00101;
    ioctl_dout = 8'hA5;
    ioctl_wr = 1'b1;
    tick(1);
    ioctl_wr = 1'b0;
    chk("a_wait_issue", 32'(ioctl_wait), 32'd1);
    chk("a_p1_a", 32'(port1_a), 32'h00080);
    chk("a_p1_ds", 32'(port1_ds), 32'd2);
    chk("a_p1_d", 32'(port1_d), 32'hA5A5);
    chk("a_dlwr", 32'(dl_wr), 32'd0);
    chk("a_core_reset_dl", 32'(core_reset), 32'd1);
    tick(1);
    chk("a_p1req", 32'(port1_req), 32'd1);
    chk("a_p2req", 32'(port2_req), 32'd0);
    ioctl_addr = 25'h00200;
    ioctl_dout = 8'h55;
    ioctl_wr = 1'b1;
    tick(1);
    ioctl_wr = 1'b0;
    chk("ovr_flag", 32'(dl_overrun), 32'd1);
    chk("ovr_p1_a", 32'(port1_a), 32'h00080);
    chk("ovr_p1_d", 32'(port1_d), 32'hA5A5);
    chk("a_wait_pend", 32'(ioctl_wait), 32'd1);
    tick(1);
    chk("a_wait_pend2", 32'(ioctl_wait), 32'd1);
    port1_ack = 1'b1;
    tick(1);
    chk("a_wait_done", 32'(ioctl_wait), 32'd0);
    chk("a_p1req_hold", 32'(port1_req), 32'd1);
    tick(1);
    chk("ovr_not_taken", 32'(ioctl_wait), 32'd0);

    // region S, port2 acks first
    ioctl_addr = 25'h1A001;
    ioctl_dout = 8'h3C;
    ioctl_wr = 1'b1;
    tick(1);
    ioctl_wr = 1'b0;
    chk("s_p1_a", 32'(port1_a), 32'h0D000);
    chk("s_p1_ds", 32'(port1_ds), 32'd2);
    chk("s_p1_d", 32'(port1_d), 32'h3C3C);
    chk("s_p2_a", 32'(port2_a), 32'h00002);
    chk("s_p2_ds", 32'(port2_ds), 32'd2);
    chk("s_p2_d", 32'(port2_d), 32'h3C3C);
    tick(1);
    chk("s_p1req", 32'(port1_req), 32'd0);
    chk("s_p2req", 32'(port2_req), 32'd1);
    port2_ack = 1'b1;
    tick(1);
    chk("s_wait_p1_pend", 32'(ioctl_wait), 32'd1);
    tick(1);
    chk("s_wait_p1_pend2", 32'(ioctl_wait), 32'd1);
    port1_ack = 1'b0;
    tick(1);
    chk("s_wait_done", 32'(ioctl_wait), 32'd0);

    // region G
    ioctl_addr = 25'h32010;
    ioctl_dout = 8'h77;
    ioctl_wr = 1'b1;
    tick(1);
    ioctl_wr = 1'b0;
    chk("g_dlwr", 32'(dl_wr), 32'd1);
    chk("g_dladdr", 32'(dl_addr), 32'h10);
    chk("g_dldata", 32'(dl_data), 32'h77);
    chk("g_wait", 32'(ioctl_wait), 32'd1);
    tick(1);
    chk("g_dlwr_end", 32'(dl_wr), 32'd0);
    chk("g_wait_end", 32'(ioctl_wait), 32'd0);
    chk("g_p1req", 32'(port1_req), 32'd0);
    chk("g_p2req", 32'(port2_req), 32'd1);

    // download end and reset stretch
    ioctl_download = 1'b0;
    tick(1);
    chk("ld_loaded", 32'(rom_loaded), 32'd1);
    chk("ld_core_hi", 32'(core_reset), 32'd1);
    tick(1);
    chk("ld_core_drop", 32'(core_reset), 32'd0);
    tick(14);
    chk("ld_core_lo_end", 32'(core_reset), 32'd0);
    tick(1);
    chk("ld_core_pulse", 32'(core_reset), 32'd1);
    tick(1);
    chk("ld_core_pulse_end", 32'(core_reset), 32'd0);
    tick(3);
    chk("ld_core_stays_lo", 32'(core_reset), 32'd0);

    // reset in the middle of a handshake
    ioctl_download = 1'b1;
    ioctl_addr = 25'h00010;
    ioctl_dout = 8'h11;
    ioctl_wr = 1'b1;
    tick(1);
    ioctl_wr = 1'b0;
    tick(1);
    chk("r_p1req", 32'(port1_req), 32'd1);
    chk("r_wait", 32'(ioctl_wait), 32'd1);
    RESET = 1'b1;
    port1_ack = 1'b0;
    port2_ack = 1'b0;
    tick(1);
    chk("r_wait_clr", 32'(ioctl_wait), 32'd0);
    chk("r_p1req_clr", 32'(port1_req), 32'd0);
    chk("r_p2req_clr", 32'(port2_req), 32'd0);
    chk("r_loaded_clr", 32'(rom_loaded), 32'd0);
    chk("r_core_reset", 32'(core_reset), 32'd1);
    chk("r_overrun_clr", 32'(dl_overrun), 32'd0);
    RESET = 1'b0;
    ioctl_download = 1'b0;
    tick(2);
    chk("r_idle_after", 32'(ioctl_wait), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
